// File: rtl/fft_frame_scheduler_pkg.sv
// Shared keyword-spotting constants and the frame scheduler state encoding.
// The FFT datapath imports these same constants.
package kws_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FEED,
        WAIT_OUT,
        DRAIN
    } sched_state_t;

    localparam int unsigned FFT_SIZE  = 32;
    localparam int unsigned FFT_BIN_W = 5;

endpackage

// File: rtl/fft_frame_scheduler_if.sv
// Sample-stream, FFT handshake and bin-output bundle for fft_frame_scheduler.
// slave is the scheduler's view; master is the surrounding system's view.
interface fft_frame_scheduler_if #(
    parameter int unsigned DATA_WIDTH = 16
) ();
    import kws_pkg::*;

    logic                  enable;
    logic                  sample_valid;
    logic [DATA_WIDTH-1:0] sample_in;
    logic                  fft_ready;
    logic                  fft_valid_in;
    logic [DATA_WIDTH-1:0] fft_real_in;
    logic [DATA_WIDTH-1:0] fft_imag_in;
    logic                  fft_valid_out;
    logic [DATA_WIDTH-1:0] fft_real_out;
    logic [DATA_WIDTH-1:0] fft_imag_out;
    logic                  bin_valid;
    logic [FFT_BIN_W-1:0]  bin_index;
    logic [DATA_WIDTH-1:0] bin_real;
    logic [DATA_WIDTH-1:0] bin_imag;
    logic                  frame_done;
    logic [15:0]           frame_count;
    logic                  overrun;
    logic                  timeout;

    modport slave (
        input  enable, sample_valid, sample_in, fft_ready,
               fft_valid_out, fft_real_out, fft_imag_out,
        output fft_valid_in, fft_real_in, fft_imag_in,
               bin_valid, bin_index, bin_real, bin_imag,
               frame_done, frame_count, overrun, timeout
    );

    modport master (
        output enable, sample_valid, sample_in, fft_ready,
               fft_valid_out, fft_real_out, fft_imag_out,
        input  fft_valid_in, fft_real_in, fft_imag_in,
               bin_valid, bin_index, bin_real, bin_imag,
               frame_done, frame_count, overrun, timeout
    );

endinterface

// File: rtl/fft_frame_scheduler_sample_ring.sv
// Audio sample ring: one write port with an internal wrapping pointer
// (exported so the reader can locate the newest samples) and one async read port.
module sample_ring #(
    parameter  int unsigned DATA_WIDTH = 16,
    parameter  int unsigned RING_DEPTH = 64,
    localparam int unsigned PTR_W      = $clog2(RING_DEPTH)
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_wr_en,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic [PTR_W-1:0]      i_rd_addr,
    output logic [DATA_WIDTH-1:0] o_rd_data,
    output logic [PTR_W-1:0]      o_wr_ptr
);

    logic [DATA_WIDTH-1:0] r_mem [RING_DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;

    // Contents are don't-care after reset, so the array carries no reset.
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
        end else if (i_wr_en) begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];
    assign o_wr_ptr  = r_wr_ptr;

endmodule

// File: rtl/fft_frame_scheduler.sv
// Launches a FFT_SIZE-sample frame into the FFT every HOP samples and forwards the
// returned bins, tagged with their index, together with frame/overrun/timeout status.
module fft_frame_scheduler #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned FFT_SIZE   = 32,
    parameter int unsigned HOP        = 16,
    parameter int unsigned RING_DEPTH = 64,
    parameter int unsigned WAIT_LIMIT = 255
) (
    input  logic                  clock,
    input  logic                  reset_n,
    fft_frame_scheduler_if.slave  bus
);
    import kws_pkg::*;

    localparam int unsigned PTR_W  = $clog2(RING_DEPTH);
    localparam int unsigned CNT_W  = $clog2(FFT_SIZE + 1);
    localparam int unsigned RD_W   = $clog2(FFT_SIZE);
    localparam int unsigned WAIT_W = $clog2(WAIT_LIMIT + 1);

    sched_state_t          r_state;
    logic [CNT_W-1:0]      r_fill;
    logic [CNT_W-1:0]      r_hop_cnt;
    logic                  r_pending;
    logic                  r_overrun;
    logic                  r_timeout;
    logic [PTR_W-1:0]      r_base;
    logic [RD_W-1:0]       r_rd_cnt;
    logic [RD_W-1:0]       r_beat;
    logic [WAIT_W-1:0]     r_wait_cnt;
    logic                  r_bin_valid;
    logic [FFT_BIN_W-1:0]  r_bin_index;
    logic [DATA_WIDTH-1:0] r_bin_real;
    logic [DATA_WIDTH-1:0] r_bin_imag;
    logic                  r_frame_done;
    logic [15:0]           r_frame_count;

    logic [PTR_W-1:0]      w_wr_ptr;
    logic [PTR_W-1:0]      w_rd_addr;
    logic [DATA_WIDTH-1:0] w_rd_data;
    logic                  w_hop_done;
    logic                  w_frame_ready;
    logic                  w_launch;

    sample_ring #(
        .DATA_WIDTH (DATA_WIDTH),
        .RING_DEPTH (RING_DEPTH)
    ) u_ring (
        .i_clk     (clock),
        .i_rst_n   (reset_n),
        .i_wr_en   (bus.sample_valid),
        .i_wr_data (bus.sample_in),
        .i_rd_addr (w_rd_addr),
        .o_rd_data (w_rd_data),
        .o_wr_ptr  (w_wr_ptr)
    );

    assign w_hop_done    = bus.sample_valid && (r_hop_cnt == CNT_W'(HOP - 1));
    // fill counts the arriving sample as well
    assign w_frame_ready = r_fill >= CNT_W'(FFT_SIZE - 1);
    assign w_launch      = (r_state == IDLE) && bus.enable && r_pending && bus.fft_ready;
    assign w_rd_addr     = r_base + PTR_W'(r_rd_cnt);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= IDLE;
            r_fill        <= '0;
            r_hop_cnt     <= '0;
            r_pending     <= 1'b0;
            r_overrun     <= 1'b0;
            r_timeout     <= 1'b0;
            r_base        <= '0;
            r_rd_cnt      <= '0;
            r_beat        <= '0;
            r_wait_cnt    <= '0;
            r_bin_valid   <= 1'b0;
            r_bin_index   <= '0;
            r_bin_real    <= '0;
            r_bin_imag    <= '0;
            r_frame_done  <= 1'b0;
            r_frame_count <= '0;
        end else begin
            r_bin_valid  <= 1'b0;
            r_frame_done <= 1'b0;

            if (bus.sample_valid) begin
                if (r_fill != CNT_W'(FFT_SIZE)) begin
                    r_fill <= r_fill + CNT_W'(1);
                end
                r_hop_cnt <= w_hop_done ? '0 : r_hop_cnt + CNT_W'(1);
            end

            // A hop landing on the launch cycle re-arms pending instead of overrunning.
            if (w_hop_done && w_frame_ready) begin
                r_pending <= 1'b1;
                if (r_pending && !w_launch) begin
                    r_overrun <= 1'b1;
                end
            end else if (w_launch) begin
                r_pending <= 1'b0;
            end

            case (r_state)
                IDLE: begin
                    if (w_launch) begin
                        r_base   <= w_wr_ptr - PTR_W'(FFT_SIZE);
                        r_rd_cnt <= '0;
                        r_state  <= FEED;
                    end
                end
                FEED: begin
                    r_rd_cnt <= r_rd_cnt + RD_W'(1);
                    if (r_rd_cnt == RD_W'(FFT_SIZE - 1)) begin
                        r_wait_cnt <= '0;
                        r_state    <= WAIT_OUT;
                    end
                end
                WAIT_OUT: begin
                    if (bus.fft_valid_out) begin
                        r_bin_valid <= 1'b1;
                        r_bin_index <= '0;
                        r_bin_real  <= bus.fft_real_out;
                        r_bin_imag  <= bus.fft_imag_out;
                        r_beat      <= RD_W'(1);
                        r_state     <= DRAIN;
                    end else if (r_wait_cnt == WAIT_W'(WAIT_LIMIT)) begin
                        r_timeout <= 1'b1;
                        r_state   <= IDLE;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
                    end
                end
                DRAIN: begin
                    if (bus.fft_valid_out) begin
                        r_bin_valid <= 1'b1;
                        r_bin_index <= FFT_BIN_W'(r_beat);
                        r_bin_real  <= bus.fft_real_out;
                        r_bin_imag  <= bus.fft_imag_out;
                        r_beat      <= r_beat + RD_W'(1);
                        if (r_beat == RD_W'(FFT_SIZE - 1)) begin
                            r_frame_done  <= 1'b1;
                            r_frame_count <= r_frame_count + 16'd1;
                            r_state       <= IDLE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.fft_valid_in = (r_state == FEED);
    assign bus.fft_real_in  = (r_state == FEED) ? w_rd_data : '0;
    assign bus.fft_imag_in  = '0;
    assign bus.bin_valid    = r_bin_valid;
    assign bus.bin_index    = r_bin_index;
    assign bus.bin_real     = r_bin_real;
    assign bus.bin_imag     = r_bin_imag;
    assign bus.frame_done   = r_frame_done;
    assign bus.frame_count  = r_frame_count;
    assign bus.overrun      = r_overrun;
    assign bus.timeout      = r_timeout;

endmodule

// File: tb/tb_fft_frame_scheduler.sv
// Directed bench for fft_frame_scheduler: frame launch/feed, bin collection table,
// hop, overrun, timeout, enable hold-off and asynchronous reset mid-drain.
module tb_fft_frame_scheduler;

    localparam int unsigned DW         = 16;
    localparam int unsigned WAIT_LIMIT = 255;

    logic clock   = 1'b0;
    logic reset_n = 1'b1;
    int   total   = 0;
    int   bad     = 0;

    always #5 clock = ~clock;

    fft_frame_scheduler_if #(.DATA_WIDTH(DW)) bus ();

    fft_frame_scheduler #(
        .DATA_WIDTH (DW),
        .FFT_SIZE   (32),
        .HOP        (16),
        .RING_DEPTH (64),
        .WAIT_LIMIT (WAIT_LIMIT)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct {
        logic        fvo;
        logic [15:0] re;
        logic [15:0] im;
        logic [4:0]  e_idx;
        logic [15:0] e_re;
        logic [15:0] e_im;
        logic        e_done;
    } vec_t;

    vec_t tbl[34];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic check_zero(input string name);
        check({name, " ctl"}, {bus.fft_valid_in, bus.fft_real_in, bus.fft_imag_in, bus.bin_valid,
                               bus.bin_index, bus.frame_done, bus.overrun, bus.timeout}, 64'd0);
        check({name, " dat"}, {bus.bin_real, bus.bin_imag, bus.frame_count}, 64'd0);
    endtask

    task automatic do_reset();
        bus.enable        = 1'b0;
        bus.sample_valid  = 1'b0;
        bus.sample_in     = '0;
        bus.fft_ready     = 1'b0;
        bus.fft_valid_out = 1'b0;
        bus.fft_real_out  = '0;
        bus.fft_imag_out  = '0;
        reset_n = 1'b1;
        #1;
        reset_n = 1'b0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
    endtask

    task automatic send_run(input int first, input int n);
        for (int i = 0; i < n; i++) begin
            bus.sample_valid = 1'b1;
            bus.sample_in    = 16'(first + i);
            @(negedge clock);
        end
        bus.sample_valid = 1'b0;
    endtask

    task automatic wait_launch(input string name);
        int n = 0;
        while (bus.fft_valid_in !== 1'b1 && n < 40) begin
            @(negedge clock);
            n++;
        end
        check({name, " launch"}, 64'(bus.fft_valid_in), 64'd1);
    endtask

    task automatic check_feed(input string name, input int first);
        for (int i = 0; i < 32; i++) begin
            check(name, {bus.fft_valid_in, bus.fft_real_in, bus.fft_imag_in},
                  {1'b1, 16'(first + i), 16'h0000});
            @(negedge clock);
        end
        check({name, " end"}, 64'(bus.fft_valid_in), 64'd0);
    endtask

    task automatic return_frame(input string name);
        for (int k = 0; k < 32; k++) begin
            bus.fft_valid_out = 1'b1;
            bus.fft_real_out  = 16'(k);
            bus.fft_imag_out  = 16'(k);
            @(negedge clock);
        end
        bus.fft_valid_out = 1'b0;
        check({name, " frame_done"}, {bus.frame_done, bus.bin_index}, {1'b1, 5'd31});
    endtask

    task automatic no_launch(input string name, input int cycles);
        logic seen = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clock);
            seen = seen | bus.fft_valid_in;
        end
        check(name, 64'(seen), 64'd0);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int j;
        int n;

        j = 0;
        for (int k = 0; k < 32; k++) begin
            if (k == 11) begin
                for (int g = 0; g < 2; g++) begin
                    tbl[j].fvo = 1'b0; tbl[j].re = 16'hdead; tbl[j].im = 16'hbeef;
                    tbl[j].e_idx = '0; tbl[j].e_re = '0; tbl[j].e_im = '0; tbl[j].e_done = 1'b0;
                    j++;
                end
            end
            tbl[j].fvo = 1'b1; tbl[j].re = 16'(k); tbl[j].im = 16'(-k);
            tbl[j].e_idx = 5'(k); tbl[j].e_re = 16'(k); tbl[j].e_im = 16'(-k);
            tbl[j].e_done = (k == 31);
            j++;
        end

        // Startup, table-driven collection, then one hop
        do_reset();
        check_zero("reset");
        bus.enable    = 1'b1;
        bus.fft_ready = 1'b1;
        send_run(1, 32);
        wait_launch("startup");
        check_feed("startup feed", 1);
        for (int v = 0; v < 34; v++) begin
            bus.fft_valid_out = tbl[v].fvo;
            bus.fft_real_out  = tbl[v].re;
            bus.fft_imag_out  = tbl[v].im;
            @(negedge clock);
            if (tbl[v].fvo) begin
                check("bin", {bus.bin_valid, bus.bin_index, bus.bin_real, bus.bin_imag, bus.frame_done},
                      {1'b1, tbl[v].e_idx, tbl[v].e_re, tbl[v].e_im, tbl[v].e_done});
            end else begin
                check("gap", {bus.bin_valid, bus.frame_done}, 2'b00);
            end
        end
        bus.fft_valid_out = 1'b0;
        check("count after 1", 64'(bus.frame_count), 64'd1);
        send_run(33, 16);
        wait_launch("hop");
        check_feed("hop feed", 17);
        return_frame("hop");
        check("count after 2", 64'(bus.frame_count), 64'd2);

        // Overrun while FFT is not ready
        do_reset();
        bus.enable    = 1'b1;
        bus.fft_ready = 1'b0;
        send_run(1, 47);
        check("overrun before 48", 64'(bus.overrun), 64'd0);
        send_run(48, 1);
        check("overrun at 48", 64'(bus.overrun), 64'd1);
        send_run(49, 16);
        check("held by ready", {bus.fft_valid_in, bus.overrun}, 2'b01);
        bus.fft_ready = 1'b1;
        wait_launch("overrun");
        check_feed("overrun feed", 33);
        return_frame("overrun");
        no_launch("single launch", 20);

        // Timeout with no FFT output
        do_reset();
        bus.enable    = 1'b1;
        bus.fft_ready = 1'b1;
        send_run(101, 32);
        wait_launch("timeout");
        check_feed("timeout feed", 101);
        n = 0;
        while (bus.timeout !== 1'b1 && n < 400) begin
            @(negedge clock);
            n++;
        end
        check("timeout cycles", 64'(n), 64'(WAIT_LIMIT + 1));
        check("after timeout", {bus.timeout, bus.frame_done, bus.frame_count}, {1'b1, 1'b0, 16'd0});
        send_run(133, 16);
        wait_launch("post timeout");
        check_feed("post timeout feed", 117);
        return_frame("post timeout");

        // Enable dropped during FEED, then async reset mid-DRAIN
        do_reset();
        bus.enable    = 1'b1;
        bus.fft_ready = 1'b1;
        send_run(201, 32);
        wait_launch("enable");
        bus.enable = 1'b0;
        check_feed("enable feed", 201);
        send_run(233, 16);
        return_frame("enable");
        no_launch("held by enable", 20);
        bus.enable = 1'b1;
        wait_launch("re-enable");
        check_feed("re-enable feed", 217);
        for (int k = 0; k < 5; k++) begin
            bus.fft_valid_out = 1'b1;
            bus.fft_real_out  = 16'(k + 1);
            bus.fft_imag_out  = 16'(k + 1);
            @(negedge clock);
        end
        bus.fft_valid_out = 1'b0;
        check("mid drain", {bus.bin_valid, bus.bin_index, bus.bin_real, bus.frame_count},
              {1'b1, 5'd4, 16'd5, 16'd1});
        #2;
        reset_n = 1'b0;
        #1;
        check_zero("async reset");
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
